// File: rtl/umstr_axil_pkg.sv
// Shared AXI-lite read-path definitions: response codes and access FSM encoding.
// No logic; types and constants only.
// No flow control; consumers own their handshakes.
package umstr_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } rd_state_t;

endpackage

// File: rtl/umstr_axil_rd_resp_fifo.sv
// Response FIFO for the AXI-lite read path, head visible combinationally.
// Latency: a write is visible at the head the cycle after the push.
// Backpressure: writes while full are dropped; the producer must check count.
module umstr_axil_rd_resp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr  = wr_en && (count != CW'(DEPTH));
    assign do_rd  = rd_en && (count != '0);
    assign rd_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/umstr_axil_reg_if_rd_pipe.sv
// AXI-lite read slave bridging to a simple register read port with timeout.
// Latency: AR accepted in N -> reg_rd_en in N+1; ack in N+1 -> rvalid in N+2.
// Backpressure: R stalls are absorbed by the response FIFO; arready drops only when it is full.
module umstr_axil_reg_if_rd_pipe
    import umstr_axil_pkg::*;
#(
    parameter int         DATA_WIDTH   = 32,
    parameter int         ADDR_WIDTH   = 32,
    parameter int         TIMEOUT      = 4,
    parameter int         RESP_DEPTH   = 4,
    parameter logic [1:0] TIMEOUT_RESP = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_wait,
    input  logic                  reg_rd_ack,
    output logic                  stat_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam int FC_W  = $clog2(RESP_DEPTH) + 1;
    localparam int RSP_W = DATA_WIDTH + 2;

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [FC_W-1:0]   fifo_count;
    logic [RSP_W-1:0]  fifo_head;
    logic [RSP_W-1:0]  push_dat;
    logic              push;
    logic              ar_hs;
    logic              rd_pop;
    logic              unused_arprot;

    assign unused_arprot  = ^s_axil_arprot;
    assign s_axil_arready = (state == ST_IDLE) && (fifo_count < FC_W'(RESP_DEPTH));
    assign ar_hs          = s_axil_arvalid && s_axil_arready;
    assign reg_rd_en      = (state == ST_ACCESS);

    // Ack is checked first so a late ack on the last budget cycle still returns OKAY.
    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        push_dat     = {reg_rd_data, RESP_OKAY};
        stat_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ar_hs) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (reg_rd_ack) begin
                    push      = !rst;
                    state_nxt = ST_IDLE;
                end else if (tmo_cnt == '0) begin
                    push         = !rst;
                    push_dat     = {{DATA_WIDTH{1'b0}}, TIMEOUT_RESP};
                    stat_timeout = !rst;
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                tmo_cnt <= CNT_W'(TIMEOUT - 1);
            end else if ((state == ST_ACCESS) && !reg_rd_wait && (tmo_cnt != '0)) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) reg_rd_addr <= s_axil_araddr;
    end

    assign rd_pop                       = s_axil_rvalid && s_axil_rready;
    assign s_axil_rvalid                = (fifo_count != '0);
    assign {s_axil_rdata, s_axil_rresp} = fifo_head;

    umstr_axil_rd_resp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_dat (push_dat),
        .rd_en  (rd_pop),
        .rd_dat (fifo_head),
        .count  (fifo_count)
    );

endmodule

// File: doc/umstr_axil_reg_if_rd_pipe.md
UMSTR_AXIL_REG_IF_RD_PIPE -- requirements
Module: umstr_axil_reg_if_rd_pipe

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32: AXI-lite and register data width in bits.
REQ-002 SHALL take parameter ADDR_WIDTH, default 32: address width in bits.
REQ-003 SHALL take parameter TIMEOUT, default 4: register access budget in non-wait cycles; legal range 1..65535.
REQ-004 SHALL take parameter RESP_DEPTH, default 4: response FIFO entries; power of two, 2..64.
REQ-005 SHALL take parameter TIMEOUT_RESP, default 2'b10: RRESP returned on timeout.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  synchronous active-high reset.
REQ-009 SHALL have ports s_axil_araddr in ADDR_WIDTH, s_axil_arprot in 3 (ignored), s_axil_arvalid in 1, s_axil_arready out 1: AXI-lite AR channel.
REQ-010 SHALL have ports s_axil_rdata out DATA_WIDTH, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1: AXI-lite R channel.
REQ-011 SHALL have ports reg_rd_addr out ADDR_WIDTH, reg_rd_en out 1, reg_rd_data in DATA_WIDTH, reg_rd_wait in 1, reg_rd_ack in 1: register read port.
REQ-012 SHALL have port stat_timeout  out  1  one-cycle pulse per timed-out access.

Function
REQ-013 SHALL implement states IDLE and ACCESS; one register access in flight at most.
REQ-014 SHALL drive s_axil_arready = (state==IDLE) && (FIFO count < RESP_DEPTH), combinationally.
REQ-015 SHALL, on AR handshake in cycle N, capture araddr into reg_rd_addr, enter ACCESS, assert reg_rd_en from cycle N+1, load timeout counter with TIMEOUT-1.
REQ-016 SHALL hold reg_rd_en and reg_rd_addr stable throughout ACCESS; reg_rd_en low in IDLE.
REQ-017 SHALL, in ACCESS, decrement the counter each cycle where reg_rd_wait=0 and counter!=0; reg_rd_wait=1 freezes it.
REQ-018 SHALL complete ACCESS when reg_rd_ack=1: push {reg_rd_data, 2'b00} into FIFO, return to IDLE next cycle.
REQ-019 SHALL complete ACCESS when reg_rd_ack=0 and counter==0: push {all-zero data, TIMEOUT_RESP}, pulse stat_timeout for that cycle, return to IDLE.
REQ-020 SHALL give ack priority over timeout when both occur in the same cycle (OKAY response).
REQ-021 SHALL present FIFO head on s_axil_rdata/s_axil_rresp with s_axil_rvalid = FIFO non-empty; pop on rvalid && rready.
REQ-022 SHALL make rvalid first visible the cycle after the completing push (ack in cycle N+1 -> rvalid in N+2 when FIFO was empty).
REQ-023 SHALL accept the next AR in the cycle after completion, independent of rready (R backpressure decoupled until FIFO full).
REQ-024 SHALL, with FIFO full, hold arready low; simultaneous pop restores arready next cycle; push and pop in the same cycle leave count unchanged.
REQ-025 SHALL return responses in AR acceptance order; FIFO pointers wrap modulo RESP_DEPTH.
REQ-026 SHALL keep R outputs stable while rvalid=1 and rready=0.

Reset
REQ-027 SHALL, on rst, force state IDLE, FIFO empty, reg_rd_en=0, s_axil_rvalid=0, stat_timeout=0; s_axil_arready=1 the first cycle after reset.
REQ-028 SHALL abort an in-flight ACCESS on rst with no FIFO push; queued responses are discarded.
REQ-029 SHALL leave data registers (address, FIFO storage, rdata) unreset.

Structure
REQ-030 SHALL place RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the IDLE/ACCESS state encoding in shared package umstr_axil_pkg.
REQ-031 SHALL implement the response FIFO as sub-module umstr_axil_rd_resp_fifo (width DATA_WIDTH+2, depth RESP_DEPTH, count output).
REQ-032 SHALL size the timeout counter as $clog2(TIMEOUT)+1 bits so TIMEOUT=1 is legal.

Verification
REQ-033 SHALL cover: AR addr 0x10, ack one cycle after reg_rd_en, data 0xA5A5_0001 -> rdata 0xA5A5_0001, rresp 00, rvalid in N+2.
REQ-034 SHALL cover: TIMEOUT=4, no ack, wait=0 -> reg_rd_en high 4 cycles, rresp 10, rdata 0, one stat_timeout pulse.
REQ-035 SHALL cover: wait=1 for 10 cycles then ack -> no timeout, rresp 00.
REQ-036 SHALL cover: rready=0, 5 back-to-back ARs, RESP_DEPTH=4 -> 4 accepted, arready low; one pop -> 5th accepted; order preserved.
REQ-037 SHALL cover: rst asserted mid-ACCESS -> reg_rd_en low next cycle, rvalid 0, no response emitted; ack in reset cycle ignored.
REQ-038 SHALL cover: ack and counter==0 in the same cycle -> rresp 00, no stat_timeout.
